// File: rtl/multiword_add_pkg.sv
// Shared types and helpers for the multi-precision add/subtract sequencer.
package multiword_add_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  // Width of a word index that counts 0 .. max_words-1, never narrower than one bit.
  function automatic int widx_w(input int max_words);
    return (max_words <= 2) ? 1 : $clog2(max_words);
  endfunction

endpackage

// File: rtl/sparse_tree_adder.sv
// N_BIT adder: a prefix tree over 4-bit group generate/propagate picks each group's carry,
// then a short ripple inside every group forms the sum bits.
module sparse_tree_adder #(
  parameter int N_BIT = 32
) (
  input  logic [N_BIT-1:0] a,
  input  logic [N_BIT-1:0] b,
  input  logic             carry_in,
  output logic [N_BIT-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NG     = N_BIT / 4;
  localparam int LEVELS = (NG > 1) ? $clog2(NG) : 0;

  logic [N_BIT-1:0] bit_g;
  logic [N_BIT-1:0] bit_p;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NG-1:0]    tree_g [0:LEVELS];
  logic [NG-1:0]    tree_p [0:LEVELS];
  logic [NG:0]      grp_cin;
  logic             msb_cin;

  assign bit_g = a & b;
  assign bit_p = a ^ b;

  always_comb begin : group_gp
    grp_g = '0;
    grp_p = '0;
    for (int g = 0; g < NG; g++) begin
      grp_p[g] = &bit_p[4*g +: 4];
      grp_g[g] = bit_g[4*g+3]
               | (bit_p[4*g+3] & bit_g[4*g+2])
               | (bit_p[4*g+3] & bit_p[4*g+2] & bit_g[4*g+1])
               | ((&bit_p[4*g+1 +: 3]) & bit_g[4*g]);
    end
  end

  // carry_in is folded into group 0 so every tree output is a true group carry-out.
  always_comb begin : prefix_tree
    for (int lvl = 0; lvl <= LEVELS; lvl++) begin
      tree_g[lvl] = '0;
      tree_p[lvl] = '0;
    end
    tree_g[0]    = grp_g;
    tree_p[0]    = grp_p;
    tree_g[0][0] = grp_g[0] | (grp_p[0] & carry_in);
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      tree_g[lvl+1] = tree_g[lvl];
      tree_p[lvl+1] = tree_p[lvl];
      for (int g = (1 << lvl); g < NG; g++) begin
        tree_g[lvl+1][g] = tree_g[lvl][g] | (tree_p[lvl][g] & tree_g[lvl][g - (1 << lvl)]);
        tree_p[lvl+1][g] = tree_p[lvl][g] & tree_p[lvl][g - (1 << lvl)];
      end
    end
  end

  assign grp_cin = {tree_g[LEVELS], carry_in};

  always_comb begin : group_sum
    logic c;
    c       = 1'b0;
    sum     = '0;
    msb_cin = 1'b0;
    for (int g = 0; g < NG; g++) begin
      c = grp_cin[g];
      for (int k = 0; k < 4; k++) begin
        if (4*g + k == N_BIT - 1) msb_cin = c;
        sum[4*g+k] = bit_p[4*g+k] ^ c;
        c          = bit_g[4*g+k] | (bit_p[4*g+k] & c);
      end
    end
  end

  assign carry_out = grp_cin[NG];
  assign overflow  = msb_cin ^ carry_out;

endmodule

// File: rtl/multiword_add_sequencer.sv
// Streams multi-word add/subtract operands LSW first through one sparse_tree_adder,
// carrying between words in a register and emitting one registered result word per beat.
module multiword_add_sequencer
  import multiword_add_pkg::*;
#(
  parameter int N_BIT     = 32,
  parameter int MAX_WORDS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_first,
  input  logic                          in_last,
  input  logic                          in_sub,
  input  logic [N_BIT-1:0]              operand_1,
  input  logic [N_BIT-1:0]              operand_2,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_BIT-1:0]              out_sum,
  output logic                          out_last,
  output logic [widx_w(MAX_WORDS)-1:0]  out_word_idx,
  output logic                          out_carry,
  output logic                          out_overflow,
  output logic                          out_length_err,
  output logic                          protocol_error
);

  localparam int WIDX_W = widx_w(MAX_WORDS);

  seq_state_t        state_q, state_d;
  logic              carry_q, carry_d;
  logic              sub_q, sub_d;
  logic [WIDX_W-1:0] word_cnt, word_cnt_d;
  logic              len_over_q, len_over_d;
  logic              perr_d;

  logic              accept;
  logic              start_beat;
  logic              cont_beat;
  logic              drop_beat;
  logic              load;
  logic              eff_sub;
  logic [N_BIT-1:0]  adder_b;
  logic              adder_cin;
  logic [N_BIT-1:0]  adder_sum;
  logic              adder_carry;
  logic              adder_ovf;
  logic [WIDX_W-1:0] beat_idx;
  logic              beat_len_err;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign start_beat = accept && in_first;
  assign cont_beat  = accept && !in_first && (state_q == RUN);
  assign drop_beat  = accept && !in_first && (state_q == IDLE);

  // Subtraction is a + ~b + 1: the +1 enters as carry_in on the least-significant word only.
  assign eff_sub   = in_first ? in_sub : sub_q;
  assign adder_b   = eff_sub ? ~operand_2 : operand_2;
  assign adder_cin = in_first ? in_sub : carry_q;

  assign beat_idx     = in_first ? '0 : word_cnt;
  assign beat_len_err = cont_beat && len_over_q;

  sparse_tree_adder #(
    .N_BIT(N_BIT)
  ) u_adder (
    .a        (operand_1),
    .b        (adder_b),
    .carry_in (adder_cin),
    .sum      (adder_sum),
    .carry_out(adder_carry),
    .overflow (adder_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      carry_q    <= 1'b0;
      sub_q      <= 1'b0;
      word_cnt   <= '0;
      len_over_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      carry_q    <= carry_d;
      sub_q      <= sub_d;
      word_cnt   <= word_cnt_d;
      len_over_q <= len_over_d;
    end
  end

  // A first beat restarts identically from either state, abandoning any open transaction.
  always_comb begin
    state_d    = state_q;
    carry_d    = carry_q;
    sub_d      = sub_q;
    word_cnt_d = word_cnt;
    len_over_d = len_over_q;
    perr_d     = protocol_error;
    load       = 1'b0;
    if (start_beat) begin
      load       = 1'b1;
      carry_d    = adder_carry;
      sub_d      = in_sub;
      word_cnt_d = WIDX_W'(1);
      len_over_d = 1'b0;
      state_d    = RUN;
    end else begin
      case (state_q)
        IDLE: begin
          if (drop_beat) perr_d = 1'b1;
        end
        RUN: begin
          if (cont_beat) begin
            load       = 1'b1;
            carry_d    = adder_carry;
            word_cnt_d = word_cnt + WIDX_W'(1);
            if (word_cnt == WIDX_W'(MAX_WORDS - 1)) len_over_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (load && in_last) begin
      state_d    = IDLE;
      word_cnt_d = '0;
      len_over_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_sum        <= '0;
      out_last       <= 1'b0;
      out_word_idx   <= '0;
      out_carry      <= 1'b0;
      out_overflow   <= 1'b0;
      out_length_err <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      protocol_error <= perr_d;
      if (load) begin
        out_valid      <= 1'b1;
        out_sum        <= adder_sum;
        out_last       <= in_last;
        out_word_idx   <= beat_idx;
        out_carry      <= in_last & adder_carry;
        out_overflow   <= in_last & adder_ovf;
        out_length_err <= beat_len_err;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer: hand-computed vectors checked with immediate assertions.
module tb_multiword_add_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_first;
  logic        in_last;
  logic        in_sub;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_last;
  logic [2:0]  out_word_idx;
  logic        out_carry;
  logic        out_overflow;
  logic        out_length_err;
  logic        protocol_error;

  int   checks;
  int   failures;
  logic exp_perr;

  multiword_add_sequencer #(
    .N_BIT    (32),
    .MAX_WORDS(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_first      (in_first),
    .in_last       (in_last),
    .in_sub        (in_sub),
    .operand_1     (operand_1),
    .operand_2     (operand_2),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sum       (out_sum),
    .out_last      (out_last),
    .out_word_idx  (out_word_idx),
    .out_carry     (out_carry),
    .out_overflow  (out_overflow),
    .out_length_err(out_length_err),
    .protocol_error(protocol_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one beat at a falling edge and returns at the next falling edge, after the DUT has registered it.
  task automatic apply_stimulus(input logic v, input logic f, input logic l, input logic s,
                                input logic [31:0] a, input logic [31:0] b);
    in_valid  = v;
    in_first  = f;
    in_last   = l;
    in_sub    = s;
    operand_1 = a;
    operand_2 = b;
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic ev, input logic [31:0] es,
                              input logic el, input logic [2:0] ei, input logic ec,
                              input logic eo, input logic ee);
    logic [40:0] obs;
    logic [40:0] req;
    obs = {out_valid, out_sum, out_last, out_word_idx, out_carry, out_overflow, out_length_err, protocol_error};
    req = {ev, es, el, ei, ec, eo, ee, exp_perr};
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  task automatic check_idle(input string tag);
    logic [1:0] obs;
    logic [1:0] req;
    obs = {out_valid, protocol_error};
    req = {1'b0, exp_perr};
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, req);
    end
  endtask

  task automatic check_ready(input string tag, input logic er);
    checks++;
    assert (in_ready === er) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, in_ready, er);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    exp_perr  = 1'b0;
    rst       = 1'b1;
    out_ready = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_output("reset_state", 1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    check_ready("reset_ready", 1'b1);
    rst = 1'b0;

    $display("[TB] 64-bit add with carry between words");
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001);
    check_output("add64_w0", 1'b1, 32'h00000000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h00000001, 32'h00000000);
    check_output("add64_w1", 1'b1, 32'h00000002, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_idle("add64_drain");

    $display("[TB] 64-bit subtract 0 - 1");
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h00000000, 32'h00000001);
    check_output("sub64_w0", 1'b1, 32'hFFFFFFFF, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000);
    check_output("sub64_w1", 1'b1, 32'hFFFFFFFF, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);

    $display("[TB] single-word signed overflow");
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h7FFFFFFF, 32'h00000001);
    check_output("ovf_single", 1'b1, 32'h80000000, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_idle("ovf_drain");

    $display("[TB] backpressure in the middle of a 3-word add");
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h80000000, 32'h80000000);
    check_output("bp_w0", 1'b1, 32'h00000000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000000);
      check_output("bp_hold", 1'b1, 32'h00000000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      check_ready("bp_ready_low", 1'b0);
    end
    out_ready = 1'b1;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000000);
    check_output("bp_w1", 1'b1, 32'h00000000, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h7FFFFFFF, 32'h00000000);
    check_output("bp_w2", 1'b1, 32'h80000000, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_idle("bp_drain");

    $display("[TB] non-first beat while idle");
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h00000005, 32'h00000005);
    exp_perr = 1'b1;
    check_idle("proto_drop");
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_idle("proto_sticky");

    $display("[TB] first beat arriving mid-transaction");
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001);
    check_output("restart_w0", 1'b1, 32'h00000000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h00000010, 32'h00000020);
    check_output("restart_new_w0", 1'b1, 32'h00000030, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h00000005, 32'h00000006);
    check_output("restart_new_w1", 1'b1, 32'h0000000B, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);

    $display("[TB] 9-word transaction exceeding the word limit");
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(1'b1, (i == 0), (i == 8), 1'b0, 32'h00000001, 32'h00000001);
      check_output("len_beat", 1'b1, 32'h00000002, (i == 8), 3'(i % 8), 1'b0, 1'b0, (i == 8));
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_idle("len_drain");

    $display("[TB] reset in the middle of a transaction");
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001);
    check_output("rstmid_w0", 1'b1, 32'h00000000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    exp_perr = 1'b0;
    check_output("rstmid_cleared", 1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h00000005, 32'h00000003);
    check_output("after_rst_w0", 1'b1, 32'h00000008, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000);
    check_output("after_rst_w1", 1'b1, 32'h00000000, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_idle("after_rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
